// File: rtl/branch_resolve_bht.sv
// Branch resolution and prediction unit.
// Resolve side (EXU): decodes branch/jump conditions from the ALU flags,
// drives the PC-adder B-select, and trains a table of saturating counters.
// Predict side (IFU): a combinational read of the counter table.
module branch_resolve_bht #(
  parameter int XLEN        = 32,
  parameter int BHT_ENTRIES = 16,
  parameter int CNT_W       = 2,
  parameter int PERF_W      = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [XLEN-1:0]   pred_pc,
  output logic              pred_taken,
  input  logic              res_valid,
  input  logic [XLEN-1:0]   res_pc,
  input  logic [6:0]        opcode,
  input  logic [2:0]        func3,
  input  logic              zero_flag,
  input  logic              alu_result,
  input  logic              res_pred,
  output logic              pc_adder_b_sel,
  output logic              res_done,
  output logic              res_taken,
  output logic              mispredict,
  output logic [PERF_W-1:0] branch_cnt,
  output logic [PERF_W-1:0] mispred_cnt
);

  localparam int IDX_W = $clog2(BHT_ENTRIES);
  localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};
  // Weakly-not-taken: 2^(CNT_W-1)-1, i.e. all-ones shifted right by one.
  localparam logic [CNT_W-1:0] CNT_INIT = CNT_MAX >> 1;

  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;

  logic [CNT_W-1:0]       r_cnt [BHT_ENTRIES];
  logic [CNT_W-1:0]       w_cnt_res;
  logic [CNT_W-1:0]       w_cnt_next;
  logic [IDX_W-1:0]       w_pred_idx;
  logic [IDX_W-1:0]       w_res_idx;
  logic [BHT_ENTRIES-1:0] w_we;
  logic                   w_is_branch;
  logic                   w_is_jump;
  logic                   w_cond;
  logic                   w_taken;
  logic                   w_res_taken_next;
  logic                   w_upd;
  logic                   w_unused_bits;

  logic                   r_res_done;
  logic                   r_res_taken;
  logic                   r_mispredict;
  logic [PERF_W-1:0]      r_branch_cnt;
  logic [PERF_W-1:0]      r_mispred_cnt;

  // func3 010/011 are not valid branch encodings and decode as non-control.
  assign w_is_branch = (opcode == OP_BRANCH) && (func3 != 3'b010) && (func3 != 3'b011);
  assign w_is_jump   = (opcode == OP_JAL) || (opcode == OP_JALR);

  // Signedness is already folded into alu_result by the ALU.
  assign w_cond  = func3[2] ? alu_result : zero_flag;
  assign w_taken = w_cond ^ func3[0];

  // Independent of res_valid so it behaves like a plain combinational select.
  assign w_res_taken_next = w_is_jump | (w_is_branch & w_taken);
  assign pc_adder_b_sel   = w_res_taken_next;

  assign w_pred_idx = pred_pc[IDX_W+1:2];
  assign w_res_idx  = res_pc[IDX_W+1:2];
  assign w_upd      = res_valid & w_is_branch;

  // PC bits outside the index field do not participate in prediction.
  assign w_unused_bits = ^{pred_pc[XLEN-1:IDX_W+2], pred_pc[1:0],
                           res_pc[XLEN-1:IDX_W+2], res_pc[1:0]};

  // Predict read sees the pre-update value on a same-index write (no bypass).
  assign pred_taken = r_cnt[w_pred_idx][CNT_W-1];
  assign w_cnt_res  = r_cnt[w_res_idx];

  // Saturating increment/decrement of the resolving entry.
  always_comb begin
    w_cnt_next = w_cnt_res;
    if (w_taken) begin
      if (w_cnt_res != CNT_MAX) w_cnt_next = w_cnt_res + CNT_W'(1);
    end else begin
      if (w_cnt_res != '0) w_cnt_next = w_cnt_res - CNT_W'(1);
    end
  end

  // One write enable per entry, decoded from the resolve index.
  for (genvar gi = 0; gi < BHT_ENTRIES; gi++) begin : g_we
    assign w_we[gi] = w_upd && (w_res_idx == IDX_W'(gi));
  end

  // Counter table: reset to weakly-not-taken, train on resolved branches.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < BHT_ENTRIES; i++) r_cnt[i] <= CNT_INIT;
    end else begin
      for (int i = 0; i < BHT_ENTRIES; i++) begin
        if (w_we[i]) r_cnt[i] <= w_cnt_next;
      end
    end
  end

  // Registered resolve outcome; res_taken holds between resolves.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_res_done   <= 1'b0;
      r_res_taken  <= 1'b0;
      r_mispredict <= 1'b0;
    end else begin
      r_res_done   <= res_valid;
      r_mispredict <= res_valid & (w_is_branch | w_is_jump) & (w_res_taken_next != res_pred);
      if (res_valid) r_res_taken <= w_res_taken_next;
    end
  end

  // Performance counters count conditional branches only; they wrap.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_branch_cnt  <= '0;
      r_mispred_cnt <= '0;
    end else if (w_upd) begin
      r_branch_cnt <= r_branch_cnt + PERF_W'(1);
      if (w_taken != res_pred) r_mispred_cnt <= r_mispred_cnt + PERF_W'(1);
    end
  end

  assign res_done    = r_res_done;
  assign res_taken   = r_res_taken;
  assign mispredict  = r_mispredict;
  assign branch_cnt  = r_branch_cnt;
  assign mispred_cnt = r_mispred_cnt;

endmodule
